// File: rtl/raster_walk_pkg.sv
// Shared types, constants and the step-size helper for the raster sample walker.
// Optional SAMPLE_JITTER_EN (see sample_walker) adds per-sample jitter.
package raster_walk_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    localparam int LL = 0;
    localparam int UR = 1;

    typedef enum logic {WAIT, TEST} state_t;

    typedef logic signed [SIGFIG-1:0] coord_t;

    // One-hot subsample select to grid step; anything not one-hot walks whole pixels.
    function automatic coord_t step_size(input logic [3:0] sub);
        case (sub)
            4'b1000: return coord_t'(1 << RADIX);
            4'b0100: return coord_t'(1 << (RADIX - 1));
            4'b0010: return coord_t'(1 << (RADIX - 2));
            4'b0001: return coord_t'(1 << (RADIX - 3));
            default: return coord_t'(1 << RADIX);
        endcase
    endfunction

endpackage

// File: rtl/sample_jitter_hash.sv
// Combinational XOR-fold of a grid position into a raw (x,y) offset pair.
// Used only when sample_walker is built with SAMPLE_JITTER_EN.
module sample_jitter_hash
    import raster_walk_pkg::*;
(
    input  logic signed [SIGFIG-1:0] x,
    input  logic signed [SIGFIG-1:0] y,
    output logic signed [SIGFIG-1:0] offset_x,
    output logic signed [SIGFIG-1:0] offset_y
);

    // Caller masks the result down to the step size, so only low bits need to be well mixed.
    assign offset_x = x ^ (y << 3) ^ (x >>> 5) ^ (y >>> 7) ^ coord_t'(24'h5a5a5a);
    assign offset_y = y ^ (x << 5) ^ (y >>> 3) ^ (x >>> 9) ^ coord_t'(24'ha5a5a5);

endmodule

// File: rtl/sample_walker.sv
// Walks every subsample position of a triangle's bounding box in raster order.
// Define SAMPLE_JITTER_EN to add a hashed offset in [0, STEP) to each emitted sample.
module sample_walker
    import raster_walk_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnH,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H
);

    state_t state, state_next;
    coord_t ll_x, ll_y, ur_x, ur_y, step;
    coord_t grid_x, grid_y;
    coord_t x_next, y_next;
    logic   row_wrap, last, box_degen, accept, load, advance;

    assign x_next   = grid_x + step;
    assign y_next   = grid_y + step;
    assign row_wrap = x_next > ur_x;
    assign last     = row_wrap && (y_next > ur_y);

    assign box_degen = (box_R13S[LL][0] > box_R13S[UR][0]) || (box_R13S[LL][1] > box_R13S[UR][1]);
    assign accept    = validTri_R13H && !box_degen;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            WAIT: begin
                if (accept) begin
                    load       = 1'b1;
                    state_next = TEST;
                end
            end
            TEST: begin
                if (!last)       advance    = 1'b1;
                else if (accept) load       = 1'b1;
                else             state_next = WAIT;
            end
            default: state_next = WAIT;
        endcase
    end

    assign halt_RnnnnH    = (state == TEST) && !last;
    assign validSamp_R14H = (state == TEST);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state      <= WAIT;
            // NOTE: the latched triangle and colour are outputs with defined reset values, so they are reset too.
            tri_R14S   <= '{default: '0};
            color_R14U <= '{default: '0};
            ll_x       <= '0;
            ll_y       <= '0;
            ur_x       <= '0;
            ur_y       <= '0;
            step       <= coord_t'(1);  // keeps the jitter mask at zero while idle after reset
            grid_x     <= '0;
            grid_y     <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                tri_R14S   <= tri_R13S;
                color_R14U <= color_R13U;
                ll_x       <= box_R13S[LL][0];
                ll_y       <= box_R13S[LL][1];
                ur_x       <= box_R13S[UR][0];
                ur_y       <= box_R13S[UR][1];
                step       <= step_size(subSample_RnnnnU);
                grid_x     <= box_R13S[LL][0];
                grid_y     <= box_R13S[LL][1];
            end else if (advance) begin
                if (row_wrap) begin
                    grid_x <= ll_x;
                    grid_y <= y_next;
                end else begin
                    grid_x <= x_next;
                end
            end
        end
    end

`ifdef SAMPLE_JITTER_EN
    coord_t hash_x, hash_y, jitter_mask;

    sample_jitter_hash u_hash (
        .x        (grid_x),
        .y        (grid_y),
        .offset_x (hash_x),
        .offset_y (hash_y)
    );

    assign jitter_mask    = step - coord_t'(1);
    assign sample_R14S[0] = grid_x + (hash_x & jitter_mask);
    assign sample_R14S[1] = grid_y + (hash_y & jitter_mask);
`else
    assign sample_R14S[0] = grid_x;
    assign sample_R14S[1] = grid_y;
`endif

endmodule

// File: tb/tb_sample_walker.sv
// Self-checking bench for sample_walker: directed table, hand sequences, and random boxes
// checked against a queue-based raster model.
module tb_sample_walker;
    import raster_walk_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic signed [SIGFIG-1:0] tri_in [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_in [COLORS];
    logic signed [SIGFIG-1:0] box_in [2][2];
    logic                     valid_tri;
    logic        [3:0]        sub;
    logic                     halt;
    logic signed [SIGFIG-1:0] tri_out [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_out [COLORS];
    logic signed [SIGFIG-1:0] sample_out [2];
    logic                     valid_samp;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {int x; int y;} pt_t;

    typedef struct {
        logic [3:0] sub;
        int llx, lly, urx, ury;
        int count;
        int fx, fy, lx, ly;
    } vec_t;

    sample_walker dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (color_in),
        .box_R13S         (box_in),
        .validTri_R13H    (valid_tri),
        .subSample_RnnnnU (sub),
        .halt_RnnnnH      (halt),
        .tri_R14S         (tri_out),
        .color_R14U       (color_out),
        .sample_R14S      (sample_out),
        .validSamp_R14H   (valid_samp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_step(input logic [3:0] s);
        if (s == 4'b1000) return 1024;
        if (s == 4'b0100) return 512;
        if (s == 4'b0010) return 256;
        if (s == 4'b0001) return 128;
        return 1024;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic [3:0] s, input int llx, input int lly, input int urx, input int ury);
        sub          = s;
        box_in[0][0] = SIGFIG'(llx);
        box_in[0][1] = SIGFIG'(lly);
        box_in[1][0] = SIGFIG'(urx);
        box_in[1][1] = SIGFIG'(ury);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) tri_in[v][a] = SIGFIG'($urandom);
        for (int c = 0; c < COLORS; c++) color_in[c] = SIGFIG'($urandom);
        valid_tri = 1'b1;
    endtask

    // Map an emitted sample back to its grid point (identity unless jitter is built in).
    function automatic int to_grid(input int s, input int lo, input int step, input string name);
`ifdef SAMPLE_JITTER_EN
        int g;
        g = lo + ((s - lo) / step) * step;
        check({name, " jitter_in_range"}, int'((s - g) >= 0 && (s - g) < step), 1);
        return g;
`else
        return s;
`endif
    endfunction

    // Presents one triangle from WAIT and follows the walk to its end; called at a negedge.
    task automatic walk(input logic [3:0] s, input int llx, input int lly, input int urx, input int ury,
                        input string tag, output int cnt, output int fx, output int fy,
                        output int lx, output int ly);
        pt_t q[$];
        int step, gx, gy, exp_tri, exp_col;
        step = model_step(s);
        for (int y = lly; y <= ury; y += step)
            for (int x = llx; x <= urx; x += step) q.push_back('{x, y});
        present(s, llx, lly, urx, ury);
        exp_tri = int'(tri_in[2][1]);
        exp_col = int'(color_in[1]);
        next_cycle();
        valid_tri = 1'b0;
        if (q.size() == 0) check({tag, " degen_halt"}, int'(halt), 0);
        cnt = 0; fx = 0; fy = 0; lx = 0; ly = 0;
        while (valid_samp && cnt < 64) begin
            gx = to_grid(int'(sample_out[0]), llx, step, tag);
            gy = to_grid(int'(sample_out[1]), lly, step, tag);
            if (cnt < q.size()) begin
                check({tag, " x"}, gx, q[cnt].x);
                check({tag, " y"}, gy, q[cnt].y);
            end
            check({tag, " halt"}, int'(halt), int'(cnt < int'(q.size()) - 1));
            if (cnt == 0) begin
                fx = gx; fy = gy;
                check({tag, " tri"}, int'(tri_out[2][1]), exp_tri);
                check({tag, " color"}, int'(color_out[1]), exp_col);
            end
            lx = gx; ly = gy;
            cnt++;
            next_cycle();
        end
        check({tag, " count"}, cnt, q.size());
    endtask

    vec_t vecs[7];

    initial begin
        int cnt, fx, fy, lx, ly, step, k, w, h, llx, lly, urx, ury, exp_tri;
        logic [3:0] s;

        vecs[0] = '{4'b1000,     0,    0, 2048, 1024, 6,     0,    0, 2048, 1024};
        vecs[1] = '{4'b0010,  5120, 3072, 5120, 3072, 1,  5120, 3072, 5120, 3072};
        vecs[2] = '{4'b0010,     0,    0,  256,    0, 2,     0,    0,  256,    0};
        vecs[3] = '{4'b1000,  2048,    0, 1024,    0, 0,     0,    0,    0,    0};
        vecs[4] = '{4'b0110,     0,    0, 2048,    0, 3,     0,    0, 2048,    0};
        vecs[5] = '{4'b0001,  -256, -128,    0,    0, 6,  -256, -128,    0,    0};
        vecs[6] = '{4'b0100,  1024,  512, 2048, 1024, 6,  1024,  512, 2048, 1024};

        // Reset held with a valid triangle on the input.
        rst = 1'b0;
        present(4'b1000, 0, 0, 1024, 1024);
        next_cycle();
        next_cycle();
        check("reset valid", int'(valid_samp), 0);
        check("reset halt", int'(halt), 0);
        check("reset sample_x", int'(sample_out[0]), 0);
        check("reset sample_y", int'(sample_out[1]), 0);
        check("reset tri", int'(tri_out[0][0]), 0);
        check("reset color", int'(color_out[2]), 0);
        valid_tri = 1'b0;
        rst = 1'b1;
        next_cycle();
        check("post_reset valid", int'(valid_samp), 0);

        for (int i = 0; i < 7; i++) begin
            walk(vecs[i].sub, vecs[i].llx, vecs[i].lly, vecs[i].urx, vecs[i].ury,
                 $sformatf("vec%0d", i), cnt, fx, fy, lx, ly);
            check($sformatf("vec%0d table_count", i), cnt, vecs[i].count);
            if (vecs[i].count > 0) begin
                check($sformatf("vec%0d first_x", i), fx, vecs[i].fx);
                check($sformatf("vec%0d first_y", i), fy, vecs[i].fy);
                check($sformatf("vec%0d last_x", i), lx, vecs[i].lx);
                check($sformatf("vec%0d last_y", i), ly, vecs[i].ly);
            end
            check($sformatf("vec%0d idle_halt", i), int'(halt), 0);
        end

        // Back-to-back: second triangle offered on the first walk's last cycle.
        present(4'b1000, 0, 0, 1024, 0);
        next_cycle();
        valid_tri = 1'b0;
        check("b2b a0 x", to_grid(int'(sample_out[0]), 0, 1024, "b2b a0"), 0);
        check("b2b a0 halt", int'(halt), 1);
        next_cycle();
        check("b2b a1 x", to_grid(int'(sample_out[0]), 0, 1024, "b2b a1"), 1024);
        check("b2b a1 halt", int'(halt), 0);
        present(4'b1000, 3072, 0, 3072, 1024);
        exp_tri = int'(tri_in[1][2]);
        next_cycle();
        valid_tri = 1'b0;
        check("b2b b0 valid", int'(valid_samp), 1);
        check("b2b b0 x", to_grid(int'(sample_out[0]), 3072, 1024, "b2b b0"), 3072);
        check("b2b b0 y", to_grid(int'(sample_out[1]), 0, 1024, "b2b b0"), 0);
        check("b2b b0 tri", int'(tri_out[1][2]), exp_tri);
        check("b2b b0 halt", int'(halt), 1);
        next_cycle();
        check("b2b b1 y", to_grid(int'(sample_out[1]), 0, 1024, "b2b b1"), 1024);
        check("b2b b1 halt", int'(halt), 0);
        next_cycle();
        check("b2b end valid", int'(valid_samp), 0);

        // Reset during the third sample of a six-sample walk.
        present(4'b1000, 0, 0, 2048, 1024);
        next_cycle();
        valid_tri = 1'b0;
        next_cycle();
        next_cycle();
        check("midrst s2 x", to_grid(int'(sample_out[0]), 0, 1024, "midrst"), 2048);
        check("midrst s2 valid", int'(valid_samp), 1);
        rst = 1'b0;
        next_cycle();
        check("midrst valid", int'(valid_samp), 0);
        check("midrst halt", int'(halt), 0);
        check("midrst sample_x", int'(sample_out[0]), 0);
        check("midrst tri", int'(tri_out[2][2]), 0);
        rst = 1'b1;
        next_cycle();
        check("midrst wait", int'(valid_samp), 0);

        // Random boxes, including non-one-hot steps and occasional degenerate boxes.
        for (int i = 0; i < 30; i++) begin
            k = int'($urandom_range(0, 4));
            s = (k == 4) ? 4'($urandom_range(0, 15)) : (4'b1000 >> k);
            step = model_step(s);
            w = int'($urandom_range(1, 4));
            h = int'($urandom_range(1, 4));
            llx = (int'($urandom_range(0, 40)) - 20) * step;
            lly = (int'($urandom_range(0, 40)) - 20) * step;
            urx = llx + (w - 1) * step;
            ury = lly + (h - 1) * step;
            if ($urandom_range(0, 7) == 0) urx = llx - step;
            walk(s, llx, lly, urx, ury, $sformatf("rnd%0d", i), cnt, fx, fy, lx, ly);
            if ($urandom_range(0, 1) == 1) next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_walker.md
# sample_walker

Rasterizer stage that drives the sample test's input interface. Accepts one triangle plus its subsample-snapped bounding box and walks every sample position inside the box in raster order. It emits one sample per cycle with the triangle and colour held alongside it. While the walk is in progress it stalls the upstream bounding-box stage through a halt signal.

## Interface
- SIGFIG, 24, bits in position and colour
- RADIX, 10, fraction bits in position
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x, y, z)
- COLORS, 3, colour channels

- clk  in  1  clock; one clock domain, all state on rising edge
- rst  in  1  reset; synchronous, active-low
- tri_R13S  in  signed SIGFIG x [VERTS][AXIS]  triangle from the bounding-box stage
- color_R13U  in  SIGFIG x [COLORS]  triangle colour
- box_R13S  in  signed SIGFIG x [2][2]  [0]=lower-left, [1]=upper-right, each (x,y); already snapped to the subsample grid
- validTri_R13H  in  1  triangle/box valid
- subSample_RnnnnU  in  4  one-hot step select: 1000=1 px, 0100=1/2, 0010=1/4, 0001=1/8
- halt_RnnnnH  out  1  upstream must hold or not present a new triangle
- tri_R14S  out  signed SIGFIG x [VERTS][AXIS]  latched triangle
- color_R14U  out  SIGFIG x [COLORS]  latched colour
- sample_R14S  out  signed SIGFIG x [2]  sample (x,y)
- validSamp_R14H  out  1  sample valid

## Operation
- States: WAIT, TEST.
- Step size, latched at accept: STEP = 1 << (RADIX - k), where k = 0..3 for 1000/0100/0010/0001. Any value that is not one-hot selects k = 0.

WAIT
- halt_RnnnnH = 0.
- On validTri_R13H with a non-degenerate box, the block accepts:
  - latch tri, colour, box and STEP;
  - load sample = lower-left;
  - set validSamp_R14H = 1;
  - go to TEST.
- Degenerate box (ll_x > ur_x or ll_y > ur_y): the triangle is dropped, nothing is emitted, state stays WAIT.

TEST
- Next position: x += STEP.
- Row wrap: if x + STEP > ur_x, then x = ll_x and y += STEP.
- last = row wrap AND y + STEP > ur_y.
- halt_RnnnnH = TEST AND NOT last (combinational).
- On a last cycle:
  - if validTri_R13H is high, accept the new triangle exactly as in WAIT (back-to-back, no bubble) and stay in TEST;
  - otherwise set validSamp_R14H = 0 and go to WAIT.

Arithmetic
- All comparisons and additions are signed SIGFIG wide.
- Boxes are bounded by screen size, so the sums cannot overflow. This is not checked.

Outputs
- tri_R14S and color_R14U are stable for the whole walk.
- validSamp_R14H = 0 outside a walk. Payload is don't-care but held.

## Timing
- Reset: state = WAIT. validSamp_R14H, halt_RnnnnH, sample_R14S, tri_R14S and color_R14U are all 0.
- Triangle accepted at edge N: the first sample (lower-left) is valid after edge N.
- A W x H-sample box yields exactly W*H consecutive valid cycles.
- halt_RnnnnH is high for W*H - 1 of those cycles. A 1x1 box never raises halt.
- rst low at any edge abandons the walk. The next cycle shows reset values.
- No downstream backpressure: the consumer takes one sample per cycle unconditionally.

## Configuration
- SAMPLE_JITTER_EN defined:
  - sample_R14S = grid position + per-sample offset in [0, STEP) on each axis;
  - offset = hash(grid x, grid y) masked by STEP-1;
  - iteration, bounds checks and halt still use the unjittered grid position.
- SAMPLE_JITTER_EN undefined: sample_R14S equals the grid position exactly, and no hash logic is instantiated.

## Structure
- Shared package raster_walk_pkg holds:
  - the state enum {WAIT, TEST};
  - the step-size function mapping subSample to STEP;
  - box index constants LL=0, UR=1.
- Sub-module sample_jitter_hash: combinational XOR-fold of grid x/y into a 2*SIGFIG offset pair. Instantiated only under SAMPLE_JITTER_EN.

## Test plan
All values use RADIX=10.
- Reset: hold rst=0 for 2 cycles with validTri=1 -> validSamp=0, halt=0, all outputs 0.
- Walk order: subSample=1000, box (0,0)-(2048,1024) -> 6 valid cycles in order (0,0), (1024,0), (2048,0), (0,1024), (1024,1024), (2048,1024); halt high on the first 5; then validSamp=0.
- Quarter step and single sample:
  - subSample=0010, box (5120,3072)-(5120,3072) -> exactly 1 sample at (5120,3072), halt never high;
  - subSample=0010, box (0,0)-(256,0) -> 2 samples, x = 0 then 256.
- Back-to-back: second triangle presented on the last-sample cycle of the first -> accepted, its lower-left emitted the next cycle, no gap in validSamp, tri_R14S updates.
- Degenerate and illegal step:
  - box (2048,0)-(1024,0) -> no valid sample, halt stays 0;
  - subSample=0110 -> walks with a 1024 step.
- Reset mid-walk, and jitter:
  - rst=0 on the 3rd sample of a 6-sample walk -> validSamp=0 next cycle, WAIT;
  - with SAMPLE_JITTER_EN, every sample offset from its grid point is in [0, STEP).
